// File: rtl/vga_receiver.sv
`default_nettype none
// ============================================================================
// vga_receiver : XGA timing sink; recovers pixel coordinates, measures timing
//                and locks after LOCK_FRAMES consecutive clean frames.
// Rev 1.0
// ============================================================================
module vga_receiver #(
    parameter int VGA_WIDTH   = 1024,
    parameter int VGA_HEIGHT  = 768,
    parameter int COLOR_DEPTH = 8,
    parameter int H_TOTAL     = 1328,
    parameter int V_TOTAL     = 806,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             vga_hs,
    input  logic                             vga_vs,
    input  logic                             vga_blank_n,
    input  logic [3*COLOR_DEPTH-1:0]         rgb_in,
    output logic [3*COLOR_DEPTH-1:0]         rgb_out,
    output logic [$clog2(VGA_WIDTH)-1:0]     x_pixel,
    output logic [$clog2(VGA_HEIGHT)-1:0]    y_pixel,
    output logic                             pixel_valid,
    output logic                             line_start,
    output logic                             frame_start,
    output logic                             locked,
    output logic                             err,
    output logic [$clog2(H_TOTAL):0]         meas_h_total,
    output logic [$clog2(V_TOTAL):0]         meas_v_total
);
    localparam int c_XW = $clog2(VGA_WIDTH);
    localparam int c_YW = $clog2(VGA_HEIGHT);
    localparam int c_AW = $clog2(VGA_WIDTH) + 1;
    localparam int c_LW = $clog2(VGA_HEIGHT) + 1;
    localparam int c_HW = $clog2(H_TOTAL) + 1;
    localparam int c_VW = $clog2(V_TOTAL) + 1;
    localparam int c_DW = 3 * COLOR_DEPTH;

    localparam logic [c_XW-1:0] c_X_MAX  = '1;
    localparam logic [c_AW-1:0] c_A_MAX  = '1;
    localparam logic [c_AW-1:0] c_ACT_W  = c_AW'(VGA_WIDTH);
    localparam logic [c_LW-1:0] c_ACT_H  = c_LW'(VGA_HEIGHT);
    localparam logic [c_HW-1:0] c_H_TOT  = c_HW'(H_TOTAL);
    localparam logic [c_HW-1:0] c_H_WD   = c_HW'(2 * H_TOTAL);
    localparam logic [c_VW-1:0] c_V_TOT  = c_VW'(V_TOTAL);
    localparam logic [3:0]      c_LOCK_N = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_MEASURE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    logic            hs1_q, vs1_q, blank1_q, hs2_q, vs2_q, blank2_q;
    logic [c_DW-1:0] rgb1_q;
    logic            hs_rise, vs_rise, blank_rise, blank_fall;

    logic [c_XW-1:0] x_q, x_d, x_cur;
    logic [c_AW-1:0] act_q, act_d;
    logic [c_YW-1:0] y_q, y_d;
    logic [c_HW-1:0] hper_q, hper_d, meas_h_q, meas_h_d;
    logic [c_VW-1:0] vcnt_q, vcnt_d, vcnt_inc, meas_v_q, meas_v_d;
    logic [c_LW-1:0] lines_q, lines_d, lines_inc;
    logic            frame_bad_q, frame_bad_d;
    logic [3:0]      good_q, good_d;
    state_t          state_q, state_d;
    logic            err_d, line_mm, frame_mm, wd_hit;

    logic [c_DW-1:0] rgb_out_q;
    logic [c_XW-1:0] x_pix_q;
    logic [c_YW-1:0] y_pix_q;
    logic            valid_q, line_start_q, frame_start_q, locked_q, err_q;

    assign hs_rise    = hs1_q & ~hs2_q;
    assign vs_rise    = vs1_q & ~vs2_q;
    assign blank_rise = blank1_q & ~blank2_q;
    assign blank_fall = ~blank1_q & blank2_q;

    always_comb begin
        x_d         = x_q;
        act_d       = act_q;
        y_d         = y_q;
        hper_d      = hper_q;
        meas_h_d    = meas_h_q;
        vcnt_d      = vcnt_q;
        meas_v_d    = meas_v_q;
        lines_d     = lines_q;
        frame_bad_d = frame_bad_q;
        good_d      = good_q;
        state_d     = state_q;
        err_d       = 1'b0;
        line_mm     = 1'b0;
        frame_mm    = 1'b0;
        wd_hit      = 1'b0;

        x_cur = (x_q == c_X_MAX) ? x_q : x_q + 1'b1;
        if (blank_rise) x_cur = '0;

        if (blank1_q) begin
            x_d   = x_cur;
            act_d = blank_rise ? c_AW'(1) : ((act_q == c_A_MAX) ? act_q : act_q + 1'b1);
        end
        if (blank_fall && act_q != c_ACT_W) line_mm = 1'b1;

        if (vs_rise)                       y_d = '0;
        else if (blank_fall && y_q != '1)  y_d = y_q + 1'b1;

        // The period counter parks at the watchdog limit so loss of sync is flagged once
        if (hs_rise) begin
            meas_h_d = hper_q;
            hper_d   = c_HW'(1);
            if (hper_q != c_H_TOT) line_mm = 1'b1;
        end else if (hper_q != c_H_WD) begin
            hper_d = hper_q + 1'b1;
            if (hper_q == c_H_WD - 1'b1) begin
                wd_hit  = 1'b1;
                line_mm = 1'b1;
            end
        end

        // An hs edge coincident with vs belongs to the frame that is ending
        vcnt_inc  = (hs_rise && vcnt_q != '1) ? vcnt_q + 1'b1 : vcnt_q;
        lines_inc = (blank_fall && lines_q != '1) ? lines_q + 1'b1 : lines_q;
        if (vs_rise) begin
            meas_v_d    = vcnt_inc;
            vcnt_d      = '0;
            lines_d     = '0;
            frame_mm    = frame_bad_q | line_mm | (vcnt_inc != c_V_TOT) | (lines_inc != c_ACT_H);
            frame_bad_d = 1'b0;
        end else begin
            vcnt_d  = vcnt_inc;
            lines_d = lines_inc;
            if (line_mm) frame_bad_d = 1'b1;
        end

        case (state_q)
            ST_UNLOCKED: begin
                if (vs_rise) begin
                    state_d = ST_MEASURE;
                    good_d  = '0;
                end
            end
            ST_MEASURE: begin
                if (wd_hit) begin
                    state_d = ST_UNLOCKED;
                    good_d  = '0;
                end else if (vs_rise) begin
                    if (frame_mm) begin
                        good_d = '0;
                    end else begin
                        good_d = good_q + 1'b1;
                        if (good_q + 1'b1 >= c_LOCK_N) state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (line_mm || frame_mm) begin
                    err_d   = 1'b1;
                    state_d = ST_UNLOCKED;
                    good_d  = '0;
                end
            end
            default: state_d = ST_UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs1_q         <= 1'b0;
            vs1_q         <= 1'b0;
            blank1_q      <= 1'b0;
            rgb1_q        <= '0;
            hs2_q         <= 1'b0;
            vs2_q         <= 1'b0;
            blank2_q      <= 1'b0;
            x_q           <= '0;
            act_q         <= '0;
            y_q           <= '0;
            hper_q        <= '0;
            meas_h_q      <= '0;
            vcnt_q        <= '0;
            meas_v_q      <= '0;
            lines_q       <= '0;
            frame_bad_q   <= 1'b0;
            good_q        <= '0;
            state_q       <= ST_UNLOCKED;
            rgb_out_q     <= '0;
            x_pix_q       <= '0;
            y_pix_q       <= '0;
            valid_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            hs1_q         <= vga_hs;
            vs1_q         <= vga_vs;
            blank1_q      <= vga_blank_n;
            rgb1_q        <= rgb_in;
            hs2_q         <= hs1_q;
            vs2_q         <= vs1_q;
            blank2_q      <= blank1_q;
            x_q           <= x_d;
            act_q         <= act_d;
            y_q           <= y_d;
            hper_q        <= hper_d;
            meas_h_q      <= meas_h_d;
            vcnt_q        <= vcnt_d;
            meas_v_q      <= meas_v_d;
            lines_q       <= lines_d;
            frame_bad_q   <= frame_bad_d;
            good_q        <= good_d;
            state_q       <= state_d;
            rgb_out_q     <= blank1_q ? rgb1_q : '0;
            x_pix_q       <= blank1_q ? x_cur : '0;
            y_pix_q       <= blank1_q ? y_q : '0;
            valid_q       <= blank1_q;
            line_start_q  <= blank_rise;
            frame_start_q <= blank_rise && (y_q == '0);
            locked_q      <= (state_d == ST_LOCKED);
            err_q         <= err_d;
        end
    end

    assign rgb_out      = rgb_out_q;
    assign x_pixel      = x_pix_q;
    assign y_pixel      = y_pix_q;
    assign pixel_valid  = valid_q;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;
    assign locked       = locked_q;
    assign err          = err_q;
    assign meas_h_total = meas_h_q;
    assign meas_v_total = meas_v_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_receiver.sv
`default_nettype none
// ============================================================================
// tb_vga_receiver : scoreboard bench for vga_receiver on a reduced-size raster
// Rev 1.0
// ============================================================================
module tb_vga_receiver;
    localparam int H_ACT = 16, H_FP = 2, H_SY = 3, H_BP = 3;
    localparam int V_ACT = 8,  V_FP = 1, V_SY = 2, V_BP = 2;
    localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
    localparam int XW = $clog2(H_ACT);
    localparam int YW = $clog2(V_ACT);
    localparam int HW = $clog2(H_TOT) + 1;
    localparam int VW = $clog2(V_TOT) + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          vga_hs = 1'b0, vga_vs = 1'b0, vga_blank_n = 1'b0;
    logic [23:0]   rgb_in = '0;
    logic [23:0]   rgb_out;
    logic [XW-1:0] x_pixel;
    logic [YW-1:0] y_pixel;
    logic          pixel_valid, line_start, frame_start, locked, err;
    logic [HW-1:0] meas_h_total;
    logic [VW-1:0] meas_v_total;
    logic [63:0]   all_outs;

    vga_receiver #(
        .VGA_WIDTH(H_ACT), .VGA_HEIGHT(V_ACT), .COLOR_DEPTH(8),
        .H_TOTAL(H_TOT), .V_TOTAL(V_TOT), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .rgb_in(rgb_in), .rgb_out(rgb_out),
        .x_pixel(x_pixel), .y_pixel(y_pixel), .pixel_valid(pixel_valid),
        .line_start(line_start), .frame_start(frame_start),
        .locked(locked), .err(err),
        .meas_h_total(meas_h_total), .meas_v_total(meas_v_total)
    );

    assign all_outs = 64'({rgb_out, x_pixel, y_pixel, pixel_valid, line_start, frame_start,
                           locked, err, meas_h_total, meas_v_total});

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int cyc = 0;
    int exp_w = H_ACT;
    int err_cnt = 0, err_cyc = 0, lock_rises = 0, lock_cyc = 0;
    int last_hs_cyc = 0, vs_cyc = 0, px_cnt = 0;
    logic [HW-1:0] err_meas_h = '0;
    logic prev_valid = 1'b0, prev_err = 1'b0, prev_locked = 1'b0;
    logic drv_hs_prev = 1'b0, drv_vs_prev = 1'b0;
    logic [63:0] sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard for every valid pixel
    always @(negedge clk) begin
        logic [63:0] exp_pix;
        if (!reset_n) begin
            px_cnt = 0; prev_valid = 1'b0; prev_err = 1'b0; prev_locked = 1'b0;
        end else begin
            if (pixel_valid) begin
                px_cnt++;
                if (sb.size() == 0) begin
                    chk("pix_unexpected", 64'(pixel_valid), 64'(0));
                end else begin
                    exp_pix = sb.pop_front();
                    chk("pixel", 64'({rgb_out, x_pixel, y_pixel, line_start, frame_start}), exp_pix);
                end
            end else begin
                chk("blank_zero", 64'({rgb_out, line_start, frame_start}), 64'(0));
                if (prev_valid) chk("line_pixels", 64'(px_cnt), 64'(exp_w));
                px_cnt = 0;
            end
            if (err) begin
                err_cnt++;
                err_cyc    = cyc;
                err_meas_h = meas_h_total;
                chk("err_single", 64'(prev_err), 64'(0));
                chk("lock_drop", 64'(locked), 64'(0));
            end
            if (locked && !prev_locked) begin
                lock_rises++;
                lock_cyc = cyc;
            end
            prev_valid  = pixel_valid;
            prev_err    = err;
            prev_locked = locked;
        end
    end

    task automatic drive_cycle(input logic hs, input logic vs, input logic blk, input int x, input int y);
        logic [23:0]   rgb;
        logic [XW-1:0] xv;
        logic [YW-1:0] yv;
        logic [7:0]    x8, y8;
        @(posedge clk); #1;
        xv  = XW'(x);
        yv  = YW'(y);
        x8  = 8'(x);
        y8  = 8'(y);
        rgb = blk ? {x8, y8, 8'hA5} : 24'($urandom());
        vga_hs = hs; vga_vs = vs; vga_blank_n = blk; rgb_in = rgb;
        if (blk) sb.push_back(64'({rgb, xv, yv, (x == 0), (x == 0 && y == 0)}));
        if (hs && !drv_hs_prev) last_hs_cyc = cyc;
        if (vs && !drv_vs_prev) vs_cyc = cyc;
        drv_hs_prev = hs;
        drv_vs_prev = vs;
    endtask

    // One raster unit: active lines, then front porch, sync, back porch lines
    task automatic drive_frame(input int act_w, input int stretch_line, input bit hs_mask);
        for (int l = 0; l < V_TOT; l++)
            for (int p = 0; p < H_TOT + ((l == stretch_line) ? 1 : 0); p++)
                drive_cycle(!hs_mask && p >= H_ACT + H_FP && p < H_ACT + H_FP + H_SY,
                            l >= V_ACT + V_FP && l < V_ACT + V_FP + V_SY,
                            l < V_ACT && p < act_w, p, l);
    endtask

    task automatic set_idle();
        vga_hs = 1'b0; vga_vs = 1'b0; vga_blank_n = 1'b0; rgb_in = '0;
        drv_hs_prev = 1'b0; drv_vs_prev = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        set_idle();
        sb.delete();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int e0, r0;
        set_idle();
        repeat (3) @(posedge clk);
        #2 chk("reset_state", all_outs, 64'(0));
        #1 reset_n = 1'b1;

        // Nominal lock
        drive_frame(H_ACT, -1, 1'b0);
        drive_frame(H_ACT, -1, 1'b0);
        chk("lock_early", 64'(locked), 64'(0));
        drive_frame(H_ACT, -1, 1'b0);
        chk("lock_nominal", 64'(locked), 64'(1));
        chk("lock_latency", 64'(lock_cyc - vs_cyc), 64'(2));
        chk("meas_h", 64'(meas_h_total), 64'(H_TOT));
        chk("meas_v", 64'(meas_v_total), 64'(V_TOT));
        chk("err_nominal", 64'(err_cnt), 64'(0));

        // One line stretched by a clock while locked
        e0 = err_cnt;
        drive_frame(H_ACT, 3, 1'b0);
        chk("stretch_err", 64'(err_cnt - e0), 64'(1));
        chk("stretch_meas", 64'(err_meas_h), 64'(H_TOT + 1));
        chk("stretch_unlock", 64'(locked), 64'(0));
        drive_frame(H_ACT, -1, 1'b0);
        chk("stretch_relock_early", 64'(locked), 64'(0));
        drive_frame(H_ACT, -1, 1'b0);
        chk("stretch_relock", 64'(locked), 64'(1));

        // hs held low: watchdog
        e0 = err_cnt;
        drive_frame(H_ACT, -1, 1'b1);
        chk("wd_err", 64'(err_cnt - e0), 64'(1));
        chk("wd_time", 64'(err_cyc - last_hs_cyc), 64'(2 * H_TOT + 1));
        chk("wd_unlock", 64'(locked), 64'(0));
        drive_frame(H_ACT, -1, 1'b0);
        drive_frame(H_ACT, -1, 1'b0);
        chk("wd_relock_early", 64'(locked), 64'(0));
        drive_frame(H_ACT, -1, 1'b0);
        chk("wd_relock", 64'(locked), 64'(1));
        chk("wd_err_total", 64'(err_cnt - e0), 64'(1));

        // Asynchronous reset in the middle of an active line
        for (int p = 0; p < 5; p++) drive_cycle(1'b0, 1'b0, 1'b1, p, 0);
        chk("pre_reset_lock", 64'(locked), 64'(1));
        #2 reset_n = 1'b0;
        #1 chk("async_reset", all_outs, 64'(0));
        set_idle();
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        drive_frame(H_ACT, -1, 1'b0);
        drive_frame(H_ACT, -1, 1'b0);
        chk("rst_relock_early", 64'(locked), 64'(0));
        drive_frame(H_ACT, -1, 1'b0);
        chk("rst_relock", 64'(locked), 64'(1));
        chk("rst_lock_latency", 64'(lock_cyc - vs_cyc), 64'(2));

        // Short active width with correct totals never locks
        do_reset();
        exp_w = H_ACT - 2;
        e0 = err_cnt;
        r0 = lock_rises;
        repeat (5) drive_frame(H_ACT - 2, -1, 1'b0);
        chk("narrow_locked", 64'(locked), 64'(0));
        chk("narrow_lock_rises", 64'(lock_rises - r0), 64'(0));
        chk("narrow_err", 64'(err_cnt - e0), 64'(0));
        chk("narrow_meas_h", 64'(meas_h_total), 64'(H_TOT));
        chk("narrow_meas_v", 64'(meas_v_total), 64'(V_TOT));

        repeat (4) @(posedge clk);
        #1 chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vga_receiver.md
Name: vga_receiver

Overview:
- Sink end of the XGA video timing interface.
- Samples vga_hs/vga_vs/vga_blank_n plus RGB from a source. Recovers the active-pixel coordinates and a valid strobe, and measures line and frame timing.
- Declares lock once a configured number of consecutive frames match the expected geometry.
- Used as a capture front end and as a loopback checker for the display driver.

Parameters:
- vga_width, 1024, active pixels per line
- vga_height, 768, active lines per frame
- color_depth, 8, bits per colour channel
- h_total, 1328, expected clocks per line (active + front + sync + back)
- v_total, 806, expected lines per frame
- lock_frames, 2, consecutive clean frames required to lock (1..15)

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- vga_hs  in  1  horizontal sync, active high
- vga_vs  in  1  vertical sync, active high
- vga_blank_n  in  1  high during active video
- rgb_in  in  3*color_depth  {r,g,b} pixel data
- rgb_out  out  3*color_depth  captured pixel; 0 when not valid
- x_pixel  out  log2(vga_width)  column of the current valid pixel
- y_pixel  out  log2(vga_height)  row of the current valid pixel
- pixel_valid  out  1  rgb_out/x/y hold an active pixel
- line_start  out  1  pulse with x_pixel==0
- frame_start  out  1  pulse with x_pixel==0, y_pixel==0
- locked  out  1  timing matches parameters
- err  out  1  one-cycle pulse on a timing violation while locked
- meas_h_total  out  log2(h_total)+1  last measured hs-to-hs period, saturating
- meas_v_total  out  log2(v_total)+1  last measured lines per frame, saturating

Behaviour:
- Reset (async, reset_n=0):
  - all outputs and counters are 0; FSM is UNLOCKED.
  - Release is sampled on the next rising clk edge.
- Input stage: hs, vs, blank_n and rgb are registered once (stage 1). Edge detectors compare stage 1 against its previous value.
- Latency: pixel outputs are registered (stage 2), so each input sample appears on the outputs exactly 2 clocks later.
- Pixel path:
  - pixel_valid = stage-1 blank.
  - rgb_out = stage-1 rgb when valid, else 0.
- x counter:
  - loads 0 on a blank rising edge;
  - increments each active clock;
  - saturates at 2^width-1.
- y counter:
  - 0 after the first vs rising edge;
  - increments on each blank falling edge;
  - saturates.
  - frame_start is asserted only when y==0.
- Horizontal measurement:
  - The period counter restarts at each hs rising edge and publishes its value to meas_h_total.
  - The active-width counter is checked against vga_width at each blank falling edge.
- Watchdog: if the period counter reaches 2*h_total, that counts as a line mismatch (signal loss). The counter then holds and no further mismatch is flagged until the next hs edge.
- Vertical measurement:
  - The hs-edge counter is published to meas_v_total at each vs rising edge.
  - The active-line count is checked against vga_height at the same edge.
- Line mismatch: meas period != h_total, or active width != vga_width.
- Frame mismatch: any line mismatch in the frame, lines != v_total, or active lines != vga_height.
- Same-cycle edges: when hs and vs rising edges coincide, the hs edge is counted in the ending frame first.
- FSM:
  - UNLOCKED: on a vs rising edge, go to MEASURE with good_cnt=0 and the frame-bad flag cleared.
  - MEASURE, at each vs rising edge:
    - clean frame: good_cnt+1; when it reaches lock_frames, go to LOCKED;
    - bad frame: good_cnt=0.
  - MEASURE, on watchdog: go to UNLOCKED.
  - LOCKED: on any line or frame mismatch or watchdog, pulse err for one clock and go to UNLOCKED.
- locked = (state==LOCKED), registered. It deasserts in the same cycle err pulses.
- The pixel path runs independently of lock; coordinates are produced while unlocked.

Test Plan:
- Nominal 1024x768 stream (front 24, sync 136, back 144; vertical 3/6/29), reset released before it starts:
  - locked rises at the vs edge ending the 2nd full frame after the first vs edge;
  - meas_h_total=1328, meas_v_total=806;
  - 1024 valid pixels per line.
- rgb_in = {x[7:0], y[7:0], 8'hA5} during active video, random during blank:
  - rgb_out equals the input 2 clocks later with matching x/y;
  - rgb_out is 0 whenever pixel_valid=0;
  - line_start and frame_start pulses land exactly on (0,y) and (0,0).
- While locked, stretch one line to 1329 clocks:
  - single-cycle err, locked=0;
  - locked reasserts after 2 clean frames.
- While locked, hold hs low:
  - err and locked=0 when the watchdog hits 2656 clocks with no hs edge;
  - no relock until edges resume plus 2 clean frames.
- Active width 1000 with correct totals: locked never asserts over 5 frames; err stays 0.
- reset_n pulsed low mid-line while locked:
  - all outputs are 0 immediately, without waiting for clk;
  - relock follows the full UNLOCKED -> MEASURE -> LOCKED sequence.
